mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch requester (I) and its load/store requester (D).
- Arbitrates, issues one transaction at a time, waits for a variable-latency acknowledge and returns read data to the owner.
- Drives stall_if and stall_mem into the hazard unit while a requester waits.
- Data requests win by default, with a starvation guard for fetch and a watchdog for hung memory.

Parameters:
- MAX_DBURST, 4, max consecutive D grants while i_req is pending before I is forced.
- TIMEOUT, 16, max cycles the arbiter waits for mem_ack before aborting the transaction (>=2).

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- i_req  input  1  fetch request, level; held until i_ready
- i_addr  input  32  fetch byte address
- i_rdata  output  32  fetched instruction word
- i_ready  output  1  one-cycle completion pulse for I
- d_req  input  1  data request, level; held until d_ready
- d_we  input  1  1=store, 0=load
- d_addr  input  32  data byte address
- d_wdata  input  32  store data, already lane-masked
- d_be  input  4  store byte enables
- d_rdata  output  32  load word
- d_ready  output  1  one-cycle completion pulse for D
- d_err  output  1  qualifies d_ready: transaction timed out
- i_err  output  1  qualifies i_ready: transaction timed out
- mem_en  output  1  memory command strobe, one cycle per transaction
- mem_we  output  1  write command
- mem_addr  output  32  word-aligned address (addr[1:0] forced 0)
- mem_wdata  output  32  write data
- mem_be  output  4  byte enables; 4'b1111 for reads
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  transaction complete
- stall_if  output  1  i_req & ~i_ready
- stall_mem  output  1  d_req & ~d_ready

Behaviour:
- Reset: state=IDLE; owner=none; burst and timeout counters 0; all registered outputs 0.
  - i_rdata and d_rdata clear to 0; mem_* outputs clear to 0.
  - Reset mid-transaction abandons it; a later mem_ack arriving in IDLE is ignored.
- FSM IDLE -> ISSUE -> WAIT -> IDLE. The memory command is registered in the IDLE->ISSUE transition.
- IDLE:
  - Eligible requesters exclude any requester whose ready pulse is high this cycle. Its req is ignored that cycle.
  - If both are eligible: D wins unless burst_cnt==MAX_DBURST, in which case I wins.
  - If a winner exists, latch the command and go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle.
  - If mem_ack is high, complete; otherwise go to WAIT.
- WAIT: mem_en=0 and the command outputs are held stable.
  - Complete on mem_ack.
  - Abort when timeout_cnt reaches TIMEOUT-1.
- Complete (registered): next cycle is IDLE with the owner's ready=1 for one cycle.
  - Owner rdata <= mem_rdata for reads.
  - d_rdata is unchanged on stores.
- Abort: same as complete, but owner rdata <= 0 and owner err=1 with ready.
- Latency: req in cycle 0 (IDLE) -> mem_en cycle 1 -> ack cycle N>=1 -> ready cycle N+1. With zero-wait memory, ready arrives in cycle 2.
- Back-to-back: the next grant decision is made in the ready cycle; mem_en for it follows in the next cycle.
- burst_cnt:
  - Increments on each D grant while i_req=1, saturating at MAX_DBURST.
  - Clears on any I grant, or on a D grant with i_req=0.
- timeout_cnt counts cycles in ISSUE+WAIT and clears on entry to ISSUE.
- Request changes: input changes after the grant do not affect the in-flight transaction. A requester dropping req early does not cancel it; ready still pulses.
- mem_ack outside ISSUE/WAIT is ignored.

Test Plan:
- I only, i_addr=0x100, mem_ack in cycle 1 with mem_rdata=0x00500093 -> mem_en cycle 1, mem_addr=0x100, mem_be=4'hF; i_ready and i_rdata=0x00500093 in cycle 2; stall_if high cycles 0-1.
- I and D raised together, D is a store to 0x203 with d_be=4'b1000 and d_wdata=0xAB000000 -> D granted first; mem_addr=0x200, mem_we=1; I issued in the cycle after d_ready; d_rdata unchanged.
- d_req held continuously with i_req pending, MAX_DBURST=4, 1-cycle ack -> exactly 4 D transactions, then 1 I transaction, then D resumes.
- Read to 0x40 with mem_ack withheld, TIMEOUT=16 -> abort 16 cycles after ISSUE entry; d_ready=1, d_err=1, d_rdata=0; a late mem_ack is ignored.
- reset asserted low in WAIT -> all outputs 0 immediately (asynchronously); a subsequent mem_ack produces no ready; the next request is served normally.
- 3-cycle ack latency, load to 0x44 with mem_rdata=0xDEADBEEF -> command outputs stable through WAIT; mem_en exactly one cycle; d_ready one cycle with d_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D).
// D wins by default; a burst guard forces I after MAX_DBURST D grants and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int MAX_DBURST = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        i_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem
);
  localparam int BW = $clog2(MAX_DBURST + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = D owns the in-flight transaction
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic          i_err_q, i_err_d, d_err_q, d_err_d;

  logic        i_elig, d_elig, grant_i, grant_d, abort_c, finish_c;
  logic [31:0] sel_addr;

  // A requester whose ready pulses this cycle is still holding its old req; ignore it once.
  assign i_elig   = i_req & ~i_ready_q;
  assign d_elig   = d_req & ~d_ready_q;
  assign grant_i  = i_elig & (~d_elig | (burst_q == BURST_MAX));
  assign grant_d  = d_elig & ~grant_i;
  assign abort_c  = (state_q == S_WAIT) & ~mem_ack & (tcnt_q == TO_LAST);
  assign finish_c = ((state_q == S_ISSUE) | (state_q == S_WAIT)) & (mem_ack | abort_c);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      burst_q   <= '0;
      tcnt_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      burst_q   <= burst_d;
      tcnt_q    <= tcnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    burst_d   = burst_q;
    tcnt_d    = tcnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    sel_addr  = grant_d ? d_addr : i_addr;
    case (state_q)
      S_IDLE: begin
        if (grant_i || grant_d) begin
          state_d = S_ISSUE;
          owner_d = grant_d;
          we_d    = grant_d & d_we;
          addr_d  = sel_addr & ~32'h3;
          wdata_d = grant_d ? d_wdata : 32'h0;
          be_d    = (grant_d & d_we) ? d_be : 4'hF;
          tcnt_d  = '0;
          if (grant_i || !i_req) burst_d = '0;
          else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
        end
      end
      S_ISSUE, S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (finish_c) begin
          state_d = S_IDLE;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_err_d   = abort_c;
            if (abort_c) d_rdata_d = 32'h0;
            else if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_err_d   = abort_c;
            i_rdata_d = abort_c ? 32'h0 : mem_rdata;
          end
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    stall_if  = i_req & ~i_ready_q;
    stall_mem = d_req & ~d_ready_q;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected commands/responses,
// a monitor pops and compares on every mem_en and ready pulse.
module tb_mem_port_arbiter;
  localparam int MAX_DBURST = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0, reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ready, d_ready, d_err, i_err, mem_en, mem_we, stall_if, stall_mem;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_port_arbiter #(.MAX_DBURST(MAX_DBURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err), .i_err(i_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } cmd_t;
  typedef struct { logic is_d; logic err; logic [31:0] rdata; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   en_log[$], rdy_log[$];
  int   total = 0, bad = 0, cyc = 0;
  int   ack_lat = 1, wcnt = 0;
  bit   pend = 0, inject = 0, inflight = 0;
  logic [31:0] resp_data = '0;
  cmd_t cur;
  rsp_t r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT event with empty expectation queue (cycle %0d)", name, cyc);
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.be = be;
    exp_cmd.push_back(c);
  endtask

  task automatic push_rsp(input logic is_d, input logic err, input logic [31:0] rdata);
    rsp_t x;
    x.is_d = is_d; x.err = err; x.rdata = rdata;
    exp_rsp.push_back(x);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Memory model: acks ack_lat cycles after mem_en (1 = same cycle), 0 = never; inject forces a stray ack.
  initial forever begin
    @(negedge clk);
    mem_ack = 1'b0;
    if (inject) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000; inject = 0;
    end
    if (mem_en && ack_lat != 0) begin
      pend = 1; wcnt = ack_lat - 1;
    end
    if (pend) begin
      if (wcnt == 0) begin
        mem_ack = 1'b1; mem_rdata = resp_data; pend = 0;
      end else wcnt--;
    end
    if (!reset) pend = 0;
  end

  // Monitor: commands and responses are compared in order against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (!reset) inflight = 0;
    else begin
      if (mem_en) begin
        en_log.push_back(cyc);
        if (exp_cmd.size() == 0) unexpected("mem_en");
        else begin
          cur = exp_cmd.pop_front();
          inflight = 1;
          check("mem_we", mem_we, cur.we);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_be", mem_be, cur.be);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else if (inflight) begin
        check("hold_we", mem_we, cur.we);
        check("hold_addr", mem_addr, cur.addr);
        check("hold_be", mem_be, cur.be);
        if (cur.we) check("hold_wdata", mem_wdata, cur.wdata);
      end
      if (i_ready || d_ready) begin
        rdy_log.push_back(cyc);
        inflight = 0;
        if (exp_rsp.size() == 0) unexpected("ready");
        else begin
          r = exp_rsp.pop_front();
          check("ready_owner_d", d_ready, r.is_d);
          check("ready_owner_i", i_ready, !r.is_d);
          if (r.is_d) begin
            check("d_err", d_err, r.err);
            check("d_rdata", d_rdata, r.rdata);
          end else begin
            check("i_err", i_err, r.err);
            check("i_rdata", i_rdata, r.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ready(input int n_i, input int n_d, input int budget);
    int gi = 0, gd = 0;
    for (int c = 0; c < budget && (gi < n_i || gd < n_d); c++) begin
      @(negedge clk);
      if (i_ready) begin gi++; i_req = 1'b0; end
      if (d_ready) begin gd++; d_req = 1'b0; end
    end
    check("ready_count_i", gi, n_i);
    check("ready_count_d", gd, n_d);
  endtask

  task automatic clear_logs();
    en_log.delete();
    rdy_log.delete();
  endtask

  initial begin
    int t0, dn;
    bit i_seen;
    logic [31:0] exp_d;
    exp_d = '0;

    repeat (2) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // I only, zero-wait memory
    ack_lat = 1; resp_data = 32'h0050_0093; clear_logs();
    push_cmd(1'b0, 32'h100, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b0, 32'h0050_0093);
    @(negedge clk);
    t0 = cyc; i_addr = 32'h100; i_req = 1'b1;
    #1 check("t1_stall_if_c0", stall_if, 1);
    @(negedge clk);
    check("t1_stall_if_c1", stall_if, 1);
    check("t1_mem_en_c1", mem_en, 1);
    @(negedge clk);
    check("t1_i_ready_c2", i_ready, 1);
    check("t1_stall_if_c2", stall_if, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("t1_en_cycle", at(en_log, 0), t0 + 1);
    check("t1_ready_cycle", at(rdy_log, 0), t0 + 2);

    // 3-cycle ack load; address changes after grant must not leak into the command
    ack_lat = 3; resp_data = 32'hDEAD_BEEF; clear_logs(); exp_d = 32'hDEAD_BEEF;
    push_cmd(1'b0, 32'h44, 32'h0, 4'hF);
    push_rsp(1'b1, 1'b0, exp_d);
    @(negedge clk);
    t0 = cyc; d_we = 1'b0; d_addr = 32'h44; d_be = 4'h3; d_wdata = 32'h1234_5678; d_req = 1'b1;
    @(negedge clk);
    d_addr = 32'h88;
    #1 check("t6_stall_mem", stall_mem, 1);
    wait_ready(0, 1, 20);
    @(negedge clk);
    check("t6_en_count", en_log.size(), 1);
    check("t6_en_cycle", at(en_log, 0), t0 + 1);
    check("t6_ready_cycle", at(rdy_log, 0), t0 + 4);

    // I and D together: D store first, I issued right after d_ready, d_rdata kept
    ack_lat = 1; resp_data = 32'h5555_5555; clear_logs();
    push_cmd(1'b1, 32'h200, 32'hAB00_0000, 4'b1000);
    push_cmd(1'b0, 32'h104, 32'h0, 4'hF);
    push_rsp(1'b1, 1'b0, exp_d);
    push_rsp(1'b0, 1'b0, 32'h5555_5555);
    @(negedge clk);
    t0 = cyc; i_addr = 32'h104; i_req = 1'b1;
    d_we = 1'b1; d_addr = 32'h203; d_be = 4'b1000; d_wdata = 32'hAB00_0000; d_req = 1'b1;
    wait_ready(1, 1, 20);
    @(negedge clk);
    check("t2_d_ready_cycle", at(rdy_log, 0), t0 + 2);
    check("t2_i_en_after_d_ready", at(en_log, 1), at(rdy_log, 0) + 1);
    check("t2_i_ready_cycle", at(rdy_log, 1), t0 + 4);

    // Burst guard: four D grants with I waiting, then I, then D resumes
    ack_lat = 1; resp_data = 32'h1357_2468; clear_logs(); exp_d = resp_data;
    for (int k = 0; k < 4; k++) push_cmd(1'b0, 32'h300, 32'h0, 4'hF);
    push_cmd(1'b0, 32'h500, 32'h0, 4'hF);
    push_cmd(1'b0, 32'h300, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) push_rsp(1'b1, 1'b0, resp_data);
    push_rsp(1'b0, 1'b0, resp_data);
    push_rsp(1'b1, 1'b0, resp_data);
    dn = 0; i_seen = 0;
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h300; i_addr = 32'h500; d_req = 1'b1; i_req = 1'b1;
    for (int c = 0; c < 80 && !(dn == 5 && i_seen); c++) begin
      @(negedge clk);
      if (d_ready) begin dn++; if (dn == 5) d_req = 1'b0; end
      if (i_ready) i_seen = 1;
      i_req = !i_seen && !d_ready;
    end
    check("t3_d_count", dn, 5);
    check("t3_i_seen", i_seen, 1);
    @(negedge clk);
    check("t3_cmds_left", exp_cmd.size(), 0);

    // Watchdog: no ack, abort 16 cycles after ISSUE, stray ack ignored
    ack_lat = 0; clear_logs(); exp_d = '0;
    push_cmd(1'b0, 32'h40, 32'h0, 4'hF);
    push_rsp(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    t0 = cyc; d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    wait_ready(0, 1, 40);
    check("t4_ready_cycle", at(rdy_log, 0), t0 + 1 + TIMEOUT);
    inject = 1;
    repeat (4) @(negedge clk);
    check("t4_late_ack_no_ready", rdy_log.size(), 1);
    check("t4_d_err_cleared", d_err, 0);
    check("t4_d_rdata_kept", d_rdata, 0);

    // Reset in WAIT: async clear, stray ack ignored, then normal service
    ack_lat = 0; clear_logs();
    push_cmd(1'b0, 32'h80, 32'h0, 4'hF);
    @(negedge clk);
    d_addr = 32'h80; d_req = 1'b1;
    repeat (3) @(negedge clk);
    d_req = 1'b0; reset = 1'b0;
    #1;
    check("t5_mem_en", mem_en, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_be", mem_be, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_i_rdata", i_rdata, 0);
    check("t5_d_ready", d_ready, 0);
    check("t5_d_err", d_err, 0);
    @(negedge clk);
    reset = 1'b1; inject = 1;
    repeat (4) @(negedge clk);
    check("t5_no_ready_after_reset", rdy_log.size(), 0);
    check("t5_cmds_left", exp_cmd.size(), 0);
    ack_lat = 1; resp_data = 32'hCAFE_F00D; clear_logs();
    push_cmd(1'b0, 32'h84, 32'h0, 4'hF);
    push_rsp(1'b1, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    t0 = cyc; d_addr = 32'h84; d_req = 1'b1;
    wait_ready(0, 1, 20);
    check("t5_post_ready_cycle", at(rdy_log, 0), t0 + 2);

    repeat (2) @(negedge clk);
    check("end_cmd_queue_empty", exp_cmd.size(), 0);
    check("end_rsp_queue_empty", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end
endmodule
